proc_mem_responder: RTL
=======================

// Module: proc_mem_responder
//
// PURPOSE
// - Responder end of the processor instruction and data memory request interfaces.
// - Serves fetch reads and data reads/writes from one word-addressed array.
//   Both read ports are combinational; writes are synchronous.
// - Front end: host program-load channel (val/rdy). It fills the array after reset
//   and holds the processor in reset until loading completes.
// - Watches for out-of-range and misaligned requests and latches the first one.
//
// PARAMETERS
// - DEPTH      256           array size in 32-bit words; must be a power of two
// - BASE_ADDR  32'h0000_0000 byte address of word 0
//
// PORTS
// - clk              in   1   clock
// - rst              in   1   asynchronous, active-high reset
// - imemreq_val      in   1   fetch request valid
// - imemreq_addr     in   32  fetch byte address
// - imemresp_data    out  32  fetch data, same cycle
// - dmemreq_val      in   1   data request valid
// - dmemreq_type     in   1   0 = read, 1 = write
// - dmemreq_addr     in   32  data byte address
// - dmemreq_wdata    in   32  store data
// - dmemresp_rdata   out  32  load data, same cycle
// - load_val         in   1   host load word valid
// - load_rdy         out  1   responder accepts load word
// - load_data        in   32  word to store at the load pointer
// - load_last        in   1   marks the final load word
// - proc_rst         out  1   reset to the processor; high while loading
// - err              out  1   sticky; an illegal request was seen
// - err_addr         out  32  address of the first illegal request
//
// BEHAVIOUR
// - Reset (async, rst=1):
//   - state=LOAD, ptr=0, proc_rst=1, load_rdy=1, err=0, err_addr=0.
//   - Array contents are NOT reset.
// - Address decode:
//   - off = addr - BASE_ADDR; idx = off >> 2.
//   - Legal iff addr >= BASE_ADDR, off[1:0]==0 and idx < DEPTH.
// - LOAD state:
//   - load_rdy=1 and proc_rst=1. Both response outputs read 0.
//   - dmem/imem requests are ignored; no error checking.
//   - On load_val && load_rdy at posedge: mem[ptr] <= load_data, ptr <= ptr+1.
//   - Go to RUN on the cycle after an accepted beat with load_last=1, or after
//     the beat that fills ptr==DEPTH-1 (overflow stop).
// - RUN state:
//   - load_rdy=0 and proc_rst=0; load_val is ignored.
//   - RUN is left only by rst.
// - Reads (RUN):
//   - imemresp_data = mem[idx] when imemreq_val and legal, else 0.
//   - dmemresp_rdata = mem[idx] when dmemreq_val && !dmemreq_type and legal, else 0.
// - Writes (RUN): mem[idx] <= dmemreq_wdata at posedge when
//   dmemreq_val && dmemreq_type and legal.
// - Same-cycle hazards:
//   - A read of a word being written that cycle returns the OLD value;
//     the new value is visible the next cycle.
//   - imem and dmem may hit the same word in the same cycle.
// - Errors (RUN only):
//   - A valid request with an illegal address sets err at the next posedge.
//   - That request returns 0, and an illegal write is dropped.
//   - err_addr captures the address only while err==0.
//   - If both ports are illegal in the same first cycle, the dmem address wins.
//   - err stays set until rst.
// - Reset mid-RUN: returns to LOAD with ptr=0.
//   - Old contents persist until overwritten.
//   - A reload with fewer words leaves the upper words stale.
//
// TESTING
// - Reset, then 3 load beats 0x11,0x22,0x33 (last on the 3rd):
//   - load_rdy drops and proc_rst falls 1 cycle after the 3rd beat.
//   - imem addr 0x8 then returns 0x33.
// - RUN, dmem write 0xDEAD_BEEF to 0x4 while imem reads 0x4 in the same cycle:
//   - imem returns 0x22 that cycle and 0xDEAD_BEEF the next cycle.
// - RUN, dmem read 0x6 (misaligned), then imem read of DEPTH*4:
//   - err=1 with err_addr=0x6; the second error does not change err_addr; both return 0.
// - Load DEPTH beats with load_last never set:
//   - Enters RUN after beat DEPTH; the final word is readable at (DEPTH-1)*4.
// - Assert rst mid-RUN, then load 1 word 0xAA:
//   - err clears; word 0 = 0xAA and word 1 keeps its earlier value.
// - load_val held with load_rdy=0 in RUN: no array change, ptr unchanged.

Source files
------------

// File: rtl/proc_mem_if.sv
// Processor memory request/response and host program-load signals
// bundled between the host/processor side and the memory responder.
interface proc_mem_if;
    logic        imemreq_val;
    logic [31:0] imemreq_addr;
    logic [31:0] imemresp_data;
    logic        dmemreq_val;
    logic        dmemreq_type;
    logic [31:0] dmemreq_addr;
    logic [31:0] dmemreq_wdata;
    logic [31:0] dmemresp_rdata;
    logic        load_val;
    logic        load_rdy;
    logic [31:0] load_data;
    logic        load_last;
    logic        proc_rst;
    logic        err;
    logic [31:0] err_addr;

    modport slave (
        input  imemreq_val, imemreq_addr,
        input  dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
        input  load_val, load_data, load_last,
        output imemresp_data, dmemresp_rdata,
        output load_rdy, proc_rst, err, err_addr
    );

    modport master (
        output imemreq_val, imemreq_addr,
        output dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
        output load_val, load_data, load_last,
        input  imemresp_data, dmemresp_rdata,
        input  load_rdy, proc_rst, err, err_addr
    );
endinterface

// File: rtl/proc_mem_responder.sv
// Word-addressed memory serving processor fetch and data ports, filled by a
// host load channel that holds the processor in reset until loading is done.
module proc_mem_responder #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      rst,
    proc_mem_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [31:0] r_mem [DEPTH];
    logic        r_err;
    logic [31:0] r_err_addr;

    logic        w_load_rdy;
    logic        w_proc_rst;
    logic        w_load_fire;
    logic        w_run;
    logic [31:0] w_i_off;
    logic [31:0] w_d_off;
    logic        w_i_legal;
    logic        w_d_legal;
    logic [AW-1:0] w_i_idx;
    logic [AW-1:0] w_d_idx;
    logic        w_i_hit;
    logic        w_d_rd;
    logic        w_d_wr;
    logic        w_i_bad;
    logic        w_d_bad;

    // Address decode: at or above base, word aligned, inside the array
    assign w_i_off   = bus.imemreq_addr - BASE_ADDR;
    assign w_d_off   = bus.dmemreq_addr - BASE_ADDR;
    assign w_i_legal = (bus.imemreq_addr >= BASE_ADDR) && (w_i_off[1:0] == 2'b00)
                       && (w_i_off[31:AW+2] == '0);
    assign w_d_legal = (bus.dmemreq_addr >= BASE_ADDR) && (w_d_off[1:0] == 2'b00)
                       && (w_d_off[31:AW+2] == '0);
    assign w_i_idx   = w_i_off[AW+1:2];
    assign w_d_idx   = w_d_off[AW+1:2];

    assign w_run   = (r_state == ST_RUN);
    assign w_i_hit = bus.imemreq_val && w_i_legal;
    assign w_d_rd  = bus.dmemreq_val && !bus.dmemreq_type && w_d_legal;
    assign w_d_wr  = bus.dmemreq_val &&  bus.dmemreq_type && w_d_legal;
    assign w_i_bad = bus.imemreq_val && !w_i_legal;
    assign w_d_bad = bus.dmemreq_val && !w_d_legal;

    assign w_load_fire = bus.load_val && w_load_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_LOAD;
        else     r_state <= w_state_nxt;
    end

    // Leave LOAD after the last beat, or after the beat that fills the top word
    always_comb begin
        w_state_nxt = r_state;
        w_load_rdy  = 1'b0;
        w_proc_rst  = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_load_rdy = 1'b1;
                w_proc_rst = 1'b1;
                if (bus.load_val && (bus.load_last || (r_ptr == AW'(DEPTH - 1))))
                    w_state_nxt = ST_RUN;
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_ptr <= '0;
        else if (w_load_fire) r_ptr <= r_ptr + 1'b1;
    end

    // Contents survive reset so a short reload leaves upper words intact
    always_ff @(posedge clk) begin
        if (w_load_fire)          r_mem[r_ptr]   <= bus.load_data;
        else if (w_run && w_d_wr) r_mem[w_d_idx] <= bus.dmemreq_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_run && !r_err && (w_i_bad || w_d_bad)) begin
            r_err      <= 1'b1;
            r_err_addr <= w_d_bad ? bus.dmemreq_addr : bus.imemreq_addr;
        end
    end

    assign bus.imemresp_data  = (w_run && w_i_hit) ? r_mem[w_i_idx] : '0;
    assign bus.dmemresp_rdata = (w_run && w_d_rd)  ? r_mem[w_d_idx] : '0;
    assign bus.load_rdy       = w_load_rdy;
    assign bus.proc_rst       = w_proc_rst;
    assign bus.err            = r_err;
    assign bus.err_addr       = r_err_addr;
endmodule
